// File: rtl/if_bp_pkg.sv
// Shared types and constants for the fetch stage and its branch predictor.
// The hazard select encodings are also used by the ID/EX pipeline register.
package if_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] SEL_RUN   = 2'b00;
  localparam logic [1:0] SEL_FLUSH = 2'b11;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    if (taken) begin
      case (cnt)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        WT:      nxt = ST;
        ST:      nxt = ST;
        default: nxt = WNT;
      endcase
    end else begin
      case (cnt)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        WNT:     nxt = SNT;
        SNT:     nxt = SNT;
        default: nxt = WNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/if_bp_stage_bp_table.sv
// BHT + direct-mapped BTB storage: one combinational read port on the fetch PC
// and one synchronous update port driven by EX branch resolution.
module bp_table
  import if_bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_W     = $clog2(BHT_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] rd_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        hit,
  output logic        pred,
  output logic [31:0] target
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  bht_cnt_t               bht        [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BHT_ENTRIES];
  logic [31:0]            btb_target [BHT_ENTRIES];

  logic [INDEX_W-1:0] rd_idx;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [TAG_W-1:0]   upd_tag;
  bht_cnt_t           rd_cnt;
  logic               unused_pc_lsbs;

  assign rd_idx  = rd_pc[INDEX_W+1:2];
  assign rd_tag  = rd_pc[31:INDEX_W+2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign upd_tag = upd_pc[31:INDEX_W+2];
  assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  // Prediction lookup; reads the arrays before this cycle's update lands.
  always_comb begin
    rd_cnt = bht[rd_idx];
    hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    pred   = hit && rd_cnt[1];
    if (pred) begin
      target = btb_target[rd_idx];
    end else begin
      target = 32'h0000_0000;
    end
  end

  // Training: counter always moves; BTB entry is only (re)written on taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i]        <= WNT;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'h0000_0000;
      end
      btb_valid <= '0;
    end else if (upd_valid) begin
      bht[upd_idx] <= bht_next(bht[upd_idx], upd_taken);
      if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target;
      end else begin
        btb_valid[upd_idx]  <= btb_valid[upd_idx];
      end
    end else begin
      btb_valid <= btb_valid;
    end
  end

endmodule

// File: rtl/if_bp_stage.sv
// RV32I fetch stage: PC register, BHT/BTB branch prediction and IF/ID register.
// Define IF_BP_PERF_CNT_EN to add branch / mispredict performance counters.
module if_bp_stage
  import if_bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  sel_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_redirect_pc_i,
  input  logic        ex_br_valid_i,
  input  logic [31:0] ex_br_pc_i,
  input  logic        ex_br_taken_i,
  input  logic [31:0] ex_br_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        valid_o
`ifdef IF_BP_PERF_CNT_EN
  ,
  output logic [31:0] perf_br_cnt_o,
  output logic [31:0] perf_mispred_cnt_o
`endif
);

  localparam int INDEX_W = $clog2(BHT_ENTRIES);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        stall;
  logic        bp_hit;
  logic        bp_pred;
  logic [31:0] bp_target;

  assign stall       = (sel_i == 2'b01) || (sel_i == 2'b10);
  assign imem_addr_o = pc_q;

  bp_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .INDEX_W     (INDEX_W)
  ) u_bp_table (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .rd_pc      (pc_q),
    .upd_valid  (ex_br_valid_i),
    .upd_pc     (ex_br_pc_i),
    .upd_taken  (ex_br_taken_i),
    .upd_target (ex_br_target_i),
    .hit        (bp_hit),
    .pred       (bp_pred),
    .target     (bp_target)
  );

  // Next-PC select: a redirect wins even over a stall.
  always_comb begin
    if (ex_redirect_i) begin
      next_pc = ex_redirect_pc_i;
    end else if (stall) begin
      next_pc = pc_q;
    end else if (bp_hit && bp_pred) begin
      next_pc = bp_target;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  // IF/ID register: bubble on redirect or flush, load on run, hold on stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instr_o       <= NOP_INSTR;
      pc_o          <= 32'h0000_0000;
      pred_taken_o  <= 1'b0;
      pred_target_o <= 32'h0000_0000;
      valid_o       <= 1'b0;
    end else if (ex_redirect_i || (sel_i == SEL_FLUSH)) begin
      instr_o       <= NOP_INSTR;
      pc_o          <= 32'h0000_0000;
      pred_taken_o  <= 1'b0;
      pred_target_o <= 32'h0000_0000;
      valid_o       <= 1'b0;
    end else if (sel_i == SEL_RUN) begin
      instr_o       <= imem_rdata_i;
      pc_o          <= pc_q;
      pred_taken_o  <= bp_pred;
      pred_target_o <= bp_target;
      valid_o       <= 1'b1;
    end else begin
      instr_o       <= instr_o;
      pc_o          <= pc_o;
      pred_taken_o  <= pred_taken_o;
      pred_target_o <= pred_target_o;
      valid_o       <= valid_o;
    end
  end

`ifdef IF_BP_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perf_br_cnt_o      <= 32'h0000_0000;
      perf_mispred_cnt_o <= 32'h0000_0000;
    end else begin
      if (ex_br_valid_i) begin
        perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
      end else begin
        perf_br_cnt_o <= perf_br_cnt_o;
      end
      if (ex_redirect_i) begin
        perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
      end else begin
        perf_mispred_cnt_o <= perf_mispred_cnt_o;
      end
    end
  end
`endif

endmodule
